// File: rtl/bist_ctrl.sv
// BIST sequencer: seeds the TPG/MISR, runs NUM_PATTERNS patterns, flushes the MISR and compares against GOLDEN_SIG.
// Optional abort input is built when BIST_ABORT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for start
// INIT    | TPG/MISR reset, counters and result cleared
// RUN     | TPG and MISR advancing, one pattern per cycle
// FLUSH   | MISR compacting the tail of the TPG pipeline
// COMPARE | signature sampled against the golden value
// DONE    | result held until the next start
module bist_ctrl #(
  parameter int              NUM_PATTERNS = 1000,
  parameter int              PAT_CNT_W    = 16,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              SIG_W        = 36,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef BIST_ABORT_EN
  input  logic                 abort,
`endif
  input  logic [SIG_W-1:0]     sig_in,
  output logic                 tpg_rst,
  output logic                 tpg_en,
  output logic                 misr_rst,
  output logic                 misr_en,
  output logic [PAT_CNT_W-1:0] pat_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail
);

  localparam int FL_W       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [PAT_CNT_W-1:0] LAST_PAT = PAT_CNT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [PAT_CNT_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic [FL_W-1:0]        flush_cnt_q, flush_cnt_d;
  logic                   pass_q, pass_d, fail_q, fail_d;
  logic                   tpg_rst_q, tpg_rst_d, misr_rst_q, misr_rst_d;
  logic                   tpg_en_q, tpg_en_d, misr_en_q, misr_en_d;
  logic                   busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d     = state_q;
    pat_cnt_d   = pat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pass_d      = pass_q;
    fail_d      = fail_q;

    case (state_q)
      IDLE, DONE: begin
        // Result is cleared on the way into INIT so INIT itself shows zeros.
        if (start) begin
          state_d   = INIT;
          pat_cnt_d = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
        end
      end
      INIT: state_d = RUN;
      RUN: begin
        pat_cnt_d = pat_cnt_q + PAT_CNT_W'(1);
        if (pat_cnt_q == LAST_PAT) begin
          flush_cnt_d = FL_W'(FLUSH_LOAD);
          state_d     = (FLUSH_CYCLES == 0) ? COMPARE : FLUSH;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) state_d = COMPARE;
        else flush_cnt_d = flush_cnt_q - FL_W'(1);
      end
      COMPARE: begin
        state_d = DONE;
        pass_d  = (sig_in == GOLDEN_SIG);
        fail_d  = (sig_in != GOLDEN_SIG);
      end
      default: state_d = IDLE;
    endcase

`ifdef BIST_ABORT_EN
    if (abort && (state_q inside {INIT, RUN, FLUSH, COMPARE})) begin
      state_d   = DONE;
      pat_cnt_d = pat_cnt_q;
      pass_d    = 1'b0;
      fail_d    = 1'b1;
    end
`endif

    tpg_rst_d  = (state_d == INIT);
    misr_rst_d = (state_d == INIT);
    tpg_en_d   = (state_d == RUN);
    misr_en_d  = (state_d == RUN) || (state_d == FLUSH);
    busy_d     = state_d inside {INIT, RUN, FLUSH, COMPARE};
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_cnt_q   <= '0;
      flush_cnt_q <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      tpg_rst_q   <= 1'b1;
      misr_rst_q  <= 1'b1;
      tpg_en_q    <= 1'b0;
      misr_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_cnt_q   <= pat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      tpg_rst_q   <= tpg_rst_d;
      misr_rst_q  <= misr_rst_d;
      tpg_en_q    <= tpg_en_d;
      misr_en_q   <= misr_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tpg_rst  = tpg_rst_q;
  assign misr_rst = misr_rst_q;
  assign tpg_en   = tpg_en_q;
  assign misr_en  = misr_en_q;
  assign pat_cnt  = pat_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_bist_ctrl.sv
// Bench for bist_ctrl: two instances (N=4/F=2 and N=1/F=0), expected output vectors from a cycle-position model.
module tb_bist_ctrl;
  localparam logic [35:0] GOLD = 36'h987654321;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic [35:0] sig_a = '0, sig_b = '0;
`ifdef BIST_ABORT_EN
  logic        abort_a = 1'b0, abort_b = 1'b0;
`endif
  logic        tpg_rst_a, tpg_en_a, misr_rst_a, misr_en_a, busy_a, done_a, pass_a, fail_a;
  logic        tpg_rst_b, tpg_en_b, misr_rst_b, misr_en_b, busy_b, done_b, pass_b, fail_b;
  logic [15:0] pat_cnt_a, pat_cnt_b;

  bist_ctrl #(.NUM_PATTERNS(4), .PAT_CNT_W(16), .FLUSH_CYCLES(2), .SIG_W(36), .GOLDEN_SIG(GOLD)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef BIST_ABORT_EN
    .abort(abort_a),
`endif
    .sig_in(sig_a), .tpg_rst(tpg_rst_a), .tpg_en(tpg_en_a), .misr_rst(misr_rst_a), .misr_en(misr_en_a),
    .pat_cnt(pat_cnt_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a)
  );

  bist_ctrl #(.NUM_PATTERNS(1), .PAT_CNT_W(16), .FLUSH_CYCLES(0), .SIG_W(36), .GOLDEN_SIG(GOLD)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef BIST_ABORT_EN
    .abort(abort_b),
`endif
    .sig_in(sig_b), .tpg_rst(tpg_rst_b), .tpg_en(tpg_en_b), .misr_rst(misr_rst_b), .misr_en(misr_en_b),
    .pat_cnt(pat_cnt_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b)
  );

  // {tpg_rst, tpg_en, misr_rst, misr_en, busy, done, pass, fail, pat_cnt}
  wire [23:0] vec_a = {tpg_rst_a, tpg_en_a, misr_rst_a, misr_en_a, busy_a, done_a, pass_a, fail_a, pat_cnt_a};
  wire [23:0] vec_b = {tpg_rst_b, tpg_en_b, misr_rst_b, misr_en_b, busy_b, done_b, pass_b, fail_b, pat_cnt_b};

  localparam logic [23:0] RST_VEC  = 24'hA00000;
  localparam logic [23:0] IDLE_VEC = 24'h000000;

  typedef struct {
    bit          sel;
    string       tag;
    logic [23:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs at cycle k after the edge that sampled start (k=1 is INIT).
  function automatic logic [23:0] model(input int k, input int n, input int f, input bit ok);
    logic tr, te, mr, me, bu, dn, ps, fl;
    logic [15:0] pc;
    {tr, te, mr, me, bu, dn, ps, fl} = '0;
    pc = '0;
    if (k == 1) begin
      tr = 1'b1; mr = 1'b1; bu = 1'b1;
    end else if (k >= 2 && k <= n + 1) begin
      te = 1'b1; me = 1'b1; bu = 1'b1; pc = 16'(k - 2);
    end else if (k >= n + 2 && k <= n + f + 1) begin
      me = 1'b1; bu = 1'b1; pc = 16'(n);
    end else if (k == n + f + 2) begin
      bu = 1'b1; pc = 16'(n);
    end else if (k >= n + f + 3) begin
      dn = 1'b1; pc = 16'(n); ps = ok; fl = !ok;
    end
    return {tr, te, mr, me, bu, dn, ps, fl, pc};
  endfunction

  task automatic expect_vec(input bit sel, input string tag, input logic [23:0] e);
    sb_t ent;
    ent.sel = sel;
    ent.tag = tag;
    ent.exp = e;
    sb_q.push_back(ent);
  endtask

  task automatic tick();
    sb_t ent;
    logic [23:0] obs;
    @(posedge clk);
    #1;
    n_cmp++;
    assert ((pass_a & fail_a) === 1'b0)
    else begin
      n_err++;
      $error("FAIL pass_fail_excl observed pass=%b fail=%b expected not both", pass_a, fail_a);
    end
    while (sb_q.size() > 0) begin
      ent = sb_q.pop_front();
      obs = ent.sel ? vec_b : vec_a;
      n_cmp++;
      assert (obs === ent.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", ent.tag, obs, ent.exp);
      end
    end
  endtask

  // Drives one run from IDLE/DONE; sig_in matches only while the COMPARE cycle is sampled.
  task automatic run(input bit sel, input int n, input int f, input bit ok, input bit hold,
                     input int spur, input int last_k, input string name);
    int          p;
    int          pos;
    bit          st;
    logic [35:0] sg;
    p = n + f + 3;
    for (int k = 1; k <= last_k; k++) begin
      pos = hold ? ((k - 1) % p) + 1 : k;
      st  = (k == 1) || hold || (k == spur);
      sg  = (pos == p) ? (ok ? GOLD : GOLD ^ 36'h1) : (GOLD ^ 36'h5);
      if (sel) begin
        start_b = st; sig_b = sg;
      end else begin
        start_a = st; sig_a = sg;
      end
      expect_vec(sel, $sformatf("%s_c%0d", name, pos), model(pos, n, f, ok));
      tick();
    end
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    expect_vec(0, "reset_a", RST_VEC);
    expect_vec(1, "reset_b", RST_VEC);
    tick();
    expect_vec(0, "reset_a2", RST_VEC);
    tick();
    rst = 1'b0;
    expect_vec(0, "idle_a", IDLE_VEC);
    expect_vec(1, "idle_b", IDLE_VEC);
    tick();
`ifdef BIST_ABORT_EN
    abort_a = 1'b1;
    expect_vec(0, "abort_in_idle", IDLE_VEC);
    tick();
    abort_a = 1'b0;
`endif

    run(0, 4, 2, 1'b1, 1'b0, 4, 12, "pass");
    run(0, 4, 2, 1'b0, 1'b0, 0, 11, "fail");
    run(1, 1, 0, 1'b1, 1'b0, 0, 6, "short");

    run(0, 4, 2, 1'b1, 1'b0, 0, 4, "pre_rst");
    rst = 1'b1;
    start_a = 1'b1;
    expect_vec(0, "rst_in_run", RST_VEC);
    tick();
    rst = 1'b0;
    start_a = 1'b0;
    expect_vec(0, "idle_after_rst", IDLE_VEC);
    tick();
    run(0, 4, 2, 1'b1, 1'b0, 0, 10, "post_rst");

    run(0, 4, 2, 1'b1, 1'b1, 0, 20, "b2b");

`ifdef BIST_ABORT_EN
    run(0, 4, 2, 1'b1, 1'b0, 0, 5, "pre_abort");
    abort_a = 1'b1;
    expect_vec(0, "abort_run", 24'h050003);
    tick();
    abort_a = 1'b0;
    expect_vec(0, "abort_hold", 24'h050003);
    tick();
    abort_a = 1'b1;
    expect_vec(0, "abort_in_done", 24'h050003);
    tick();
    abort_a = 1'b0;
    run(0, 4, 2, 1'b1, 1'b0, 0, 9, "post_abort");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
